// File: rtl/pe_mac_lane_array_pkg.sv
// Shared widths, mode encodings and saturation helpers for the PE MAC lane array.
package pe_mac_lane_array_pkg;

  // Quantised feature/weight width and the 9-tap adder-tree result width of the PE rows.
  localparam int unsigned QUAN_BITS     = 8;
  localparam int unsigned ADD9_ALL_BITS = 20;

  localparam int unsigned DATA_W_DEF = QUAN_BITS;
  localparam int unsigned WGT_W_DEF  = QUAN_BITS;
  localparam int unsigned ACC_W_DEF  = ADD9_ALL_BITS;

  typedef enum logic {
    MODE_CHAIN = 1'b0,
    MODE_ACCUM = 1'b1
  } mac_mode_e;

  // Signed clamp bound for a result of the given width: neg=1 gives the minimum, else the maximum.
  function automatic longint sat_limit(input int unsigned width, input logic neg);
    longint one;
    one = 64'sd1;
    if (neg) begin
      return -(one <<< (width - 1));
    end
    return (one <<< (width - 1)) - one;
  endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// One signed MAC lane: product register, chain/accumulate adder, saturate-or-wrap, local acc.
module pe_mac_lane
  import pe_mac_lane_array_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned WGT_W  = WGT_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic                     s_clk,
  input  logic                     s_rst_n,
  input  logic                     clr_i,
  input  logic                     cap_en_i,
  input  logic signed [DATA_W-1:0] feature_i,
  input  logic signed [WGT_W-1:0]  weight_i,
  input  logic                     s2_en_i,
  input  mac_mode_e                s2_mode_i,
  input  logic                     s2_sat_i,
  input  logic                     s2_last_i,
  input  logic signed [ACC_W-1:0]  shift_i,
  output logic signed [ACC_W-1:0]  result_o,
  output logic                     ovf_o
);

  localparam int unsigned PROD_W = DATA_W + WGT_W;
  localparam int unsigned SUM_W  = ACC_W + 1;

  localparam logic signed [ACC_W-1:0] AccMax = ACC_W'(sat_limit(ACC_W, 1'b0));
  localparam logic signed [ACC_W-1:0] AccMin = ACC_W'(sat_limit(ACC_W, 1'b1));

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  result_q, result_d;
  logic signed [SUM_W-1:0]  prod_ext, addend, sum;
  logic signed [ACC_W-1:0]  reduced;
  logic                     ovf;
  logic                     emit;

  // Stage 1: latch the product of the multicast sample and this lane's active weight.
  always_comb begin
    prod_d = prod_q;
    if (cap_en_i) begin
      prod_d = PROD_W'(feature_i) * PROD_W'(weight_i);
    end
  end

  // Stage 2: add partial sum or running acc one bit wider, then clamp or wrap.
  always_comb begin
    prod_ext = SUM_W'(prod_q);
    addend   = (s2_mode_i == MODE_CHAIN) ? SUM_W'(shift_i) : SUM_W'(acc_q);
    sum      = prod_ext + addend;
    ovf      = sum[ACC_W] ^ sum[ACC_W-1];
    reduced  = sum[ACC_W-1:0];
    if (ovf && s2_sat_i) begin
      reduced = sum[ACC_W] ? AccMin : AccMax;
    end
  end

  // A CHAIN sample or a window's last tap publishes the result and leaves acc at zero.
  always_comb begin
    emit     = s2_en_i && ((s2_mode_i == MODE_CHAIN) || s2_last_i);
    acc_d    = acc_q;
    result_d = result_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (s2_en_i) begin
      acc_d = emit ? '0 : reduced;
    end
    if (emit) begin
      result_d = reduced;
    end
  end

  // Lane state registers.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;
  assign ovf_o    = ovf;

endmodule

// File: rtl/pe_mac_lane_array.sv
// Multi-lane PE MAC: double-buffered weights, tap window control and sticky flags around
// LANES parallel signed MAC lanes fed by one multicast feature stream.
module pe_mac_lane_array
  import pe_mac_lane_array_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned WGT_W      = WGT_W_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned LANES      = 4,
  parameter int unsigned MAX_TAPS   = 9,
  parameter int unsigned LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     s_clk,
  input  logic                     s_rst_n,
  input  logic                     s_clr,
  input  logic                     cfg_mode,
  input  logic                     cfg_sat,
  input  logic                     w_load_valid,
  input  logic [LANE_IDX_W-1:0]    w_load_lane,
  input  logic [WGT_W-1:0]         w_load_data,
  input  logic                     w_swap,
  input  logic                     f_data_valid,
  input  logic [DATA_W-1:0]        feature_data,
  input  logic                     f_last,
  input  logic [LANES*ACC_W-1:0]   shift_data,
  output logic                     o_mac_rlst_valid,
  output logic [LANES*ACC_W-1:0]   o_mac_rlst_out,
  output logic                     o_sat_flag,
  output logic                     o_tap_err,
  output logic                     o_busy
);

  localparam int unsigned TAP_W = $clog2(MAX_TAPS + 1);
  localparam logic [TAP_W-1:0] LastTap = TAP_W'(MAX_TAPS - 1);

  logic signed [WGT_W-1:0] shadow_q [LANES];
  logic signed [WGT_W-1:0] shadow_d [LANES];
  logic signed [WGT_W-1:0] active_q [LANES];
  logic signed [WGT_W-1:0] active_d [LANES];

  logic [TAP_W-1:0] tap_cnt_q, tap_cnt_d;
  logic             s1_valid_q, s1_valid_d;
  mac_mode_e        s1_mode_q, s1_mode_d;
  logic             s1_sat_q, s1_sat_d;
  logic             s1_last_q, s1_last_d;
  logic             valid_q, valid_d;
  logic             sat_flag_q, sat_flag_d;
  logic             tap_err_q, tap_err_d;

  mac_mode_e        in_mode;
  logic             sample_in;
  logic             at_limit;
  logic             eff_last;
  logic             forced_last;
  logic             s2_en;
  logic [LANES-1:0] lane_ovf;

  // Weight banks: shadow load and bulk swap; a same-edge swap sees the pre-load shadow.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    for (int i = 0; i < LANES; i++) begin
      if (w_load_valid && (w_load_lane == LANE_IDX_W'(i))) begin
        shadow_d[i] = w_load_data;
      end
    end
    if (w_swap) begin
      active_d = shadow_q;
    end
  end

  // Weight bank registers.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Input-side control: tap window tracking, forced close at MAX_TAPS, stage-1 sideband.
  always_comb begin
    in_mode     = mac_mode_e'(cfg_mode);
    sample_in   = f_data_valid && !s_clr;
    at_limit    = (tap_cnt_q == LastTap);
    eff_last    = (in_mode == MODE_ACCUM) && (f_last || at_limit);
    forced_last = (in_mode == MODE_ACCUM) && !f_last && at_limit;

    tap_cnt_d  = tap_cnt_q;
    tap_err_d  = tap_err_q;
    s1_valid_d = sample_in;
    s1_mode_d  = s1_mode_q;
    s1_sat_d   = s1_sat_q;
    s1_last_d  = s1_last_q;

    if (s_clr) begin
      tap_cnt_d = '0;
      tap_err_d = 1'b0;
    end else if (sample_in) begin
      // A CHAIN sample also closes any open window; the lane drops its acc at stage 2.
      if (in_mode == MODE_CHAIN || eff_last) begin
        tap_cnt_d = '0;
      end else begin
        tap_cnt_d = tap_cnt_q + 1'b1;
      end
      if (forced_last) begin
        tap_err_d = 1'b1;
      end
    end

    if (sample_in) begin
      s1_mode_d = in_mode;
      s1_sat_d  = cfg_sat;
      s1_last_d = eff_last;
    end
  end

  // Output-side control: result valid pulse and sticky saturation flag.
  always_comb begin
    s2_en      = s1_valid_q && !s_clr;
    valid_d    = s2_en && ((s1_mode_q == MODE_CHAIN) || s1_last_q);
    sat_flag_d = sat_flag_q;
    if (s_clr) begin
      sat_flag_d = 1'b0;
    end else if (s2_en && (|lane_ovf)) begin
      sat_flag_d = 1'b1;
    end
  end

  // Control pipeline and flag registers.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      tap_cnt_q  <= '0;
      tap_err_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_CHAIN;
      s1_sat_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      valid_q    <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      tap_cnt_q  <= tap_cnt_d;
      tap_err_q  <= tap_err_d;
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_sat_q   <= s1_sat_d;
      s1_last_q  <= s1_last_d;
      valid_q    <= valid_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pe_mac_lane #(
      .DATA_W (DATA_W),
      .WGT_W  (WGT_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .s_clk     (s_clk),
      .s_rst_n   (s_rst_n),
      .clr_i     (s_clr),
      .cap_en_i  (sample_in),
      .feature_i (feature_data),
      .weight_i  (active_q[g]),
      .s2_en_i   (s2_en),
      .s2_mode_i (s1_mode_q),
      .s2_sat_i  (s1_sat_q),
      .s2_last_i (s1_last_q),
      .shift_i   (shift_data[g*ACC_W +: ACC_W]),
      .result_o  (o_mac_rlst_out[g*ACC_W +: ACC_W]),
      .ovf_o     (lane_ovf[g])
    );
  end

  assign o_mac_rlst_valid = valid_q;
  assign o_sat_flag       = sat_flag_q;
  assign o_tap_err        = tap_err_q;
  assign o_busy           = (tap_cnt_q != '0) || s1_valid_q;

endmodule

// File: tb/tb_pe_mac_lane_array.sv
// Directed bench for pe_mac_lane_array (ACC_W=16, LANES=4, MAX_TAPS=9).
module tb_pe_mac_lane_array;

  localparam int unsigned DW = 8;
  localparam int unsigned WW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned NL = 4;
  localparam int unsigned MT = 9;
  localparam int unsigned LW = 2;

  logic              s_clk;
  logic              s_rst_n;
  logic              s_clr;
  logic              cfg_mode;
  logic              cfg_sat;
  logic              w_load_valid;
  logic [LW-1:0]     w_load_lane;
  logic [WW-1:0]     w_load_data;
  logic              w_swap;
  logic              f_data_valid;
  logic [DW-1:0]     feature_data;
  logic              f_last;
  logic [NL*AW-1:0]  shift_data;
  logic              o_mac_rlst_valid;
  logic [NL*AW-1:0]  o_mac_rlst_out;
  logic              o_sat_flag;
  logic              o_tap_err;
  logic              o_busy;

  int checks = 0;
  int errors = 0;

  pe_mac_lane_array #(
    .DATA_W     (DW),
    .WGT_W      (WW),
    .ACC_W      (AW),
    .LANES      (NL),
    .MAX_TAPS   (MT),
    .LANE_IDX_W (LW)
  ) dut (
    .s_clk            (s_clk),
    .s_rst_n          (s_rst_n),
    .s_clr            (s_clr),
    .cfg_mode         (cfg_mode),
    .cfg_sat          (cfg_sat),
    .w_load_valid     (w_load_valid),
    .w_load_lane      (w_load_lane),
    .w_load_data      (w_load_data),
    .w_swap           (w_swap),
    .f_data_valid     (f_data_valid),
    .feature_data     (feature_data),
    .f_last           (f_last),
    .shift_data       (shift_data),
    .o_mac_rlst_valid (o_mac_rlst_valid),
    .o_mac_rlst_out   (o_mac_rlst_out),
    .o_sat_flag       (o_sat_flag),
    .o_tap_err        (o_tap_err),
    .o_busy           (o_busy)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  task automatic step();
    @(posedge s_clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input int lane, input int exp);
    logic signed [AW-1:0] obs;
    logic signed [AW-1:0] expv;
    obs  = o_mac_rlst_out[lane*AW +: AW];
    expv = AW'(exp);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s lane%0d: observed %0d expected %0d", tag, lane, obs, expv);
    end
  endtask

  task automatic load_w(input int lane, input int val);
    w_load_valid = 1'b1;
    w_load_lane  = LW'(lane);
    w_load_data  = WW'(val);
    step();
    w_load_valid = 1'b0;
  endtask

  task automatic swap();
    w_swap = 1'b1;
    step();
    w_swap = 1'b0;
  endtask

  task automatic feed(input int val, input logic last);
    f_data_valid = 1'b1;
    feature_data = DW'(val);
    f_last       = last;
    step();
    f_data_valid = 1'b0;
    f_last       = 1'b0;
  endtask

  initial begin
    s_rst_n      = 1'b0;
    s_clr        = 1'b0;
    cfg_mode     = 1'b0;
    cfg_sat      = 1'b1;
    w_load_valid = 1'b0;
    w_load_lane  = '0;
    w_load_data  = '0;
    w_swap       = 1'b0;
    f_data_valid = 1'b0;
    feature_data = '0;
    f_last       = 1'b0;
    shift_data   = '0;

    // Reset state
    #12;
    chk_bit("rst_valid", o_mac_rlst_valid, 1'b0);
    chk_bit("rst_sat", o_sat_flag, 1'b0);
    chk_bit("rst_taperr", o_tap_err, 1'b0);
    chk_bit("rst_busy", o_busy, 1'b0);
    chk_lane("rst_out", 0, 0);
    s_rst_n = 1'b1;
    step();

    // CHAIN basic: weights {1,-2,3,-4}, feature 5, partial sums 10
    load_w(0, 1);
    load_w(1, -2);
    load_w(2, 3);
    load_w(3, -4);
    swap();
    cfg_mode = 1'b0;
    for (int i = 0; i < NL; i++) shift_data[i*AW +: AW] = AW'(10);
    feed(5, 1'b0);
    chk_bit("chain_early", o_mac_rlst_valid, 1'b0);
    step();
    chk_bit("chain_valid", o_mac_rlst_valid, 1'b1);
    chk_lane("chain", 0, 15);
    chk_lane("chain", 1, 0);
    chk_lane("chain", 2, 25);
    chk_lane("chain", 3, -10);
    step();
    chk_bit("chain_pulse", o_mac_rlst_valid, 1'b0);
    chk_lane("chain_hold", 0, 15);

    // ACCUM window 1..9 with weight 2, then back-to-back window of three 1s
    for (int i = 0; i < NL; i++) load_w(i, 2);
    swap();
    cfg_mode = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      feed(k, k == 9);
      chk_bit("accum_nov", o_mac_rlst_valid, 1'b0);
    end
    feed(1, 1'b0);
    chk_bit("accum_valid", o_mac_rlst_valid, 1'b1);
    chk_lane("accum", 0, 90);
    chk_lane("accum", 3, 90);
    chk_bit("accum_taperr", o_tap_err, 1'b0);
    chk_bit("accum_busy", o_busy, 1'b1);
    feed(1, 1'b0);
    chk_bit("b2b_nov", o_mac_rlst_valid, 1'b0);
    feed(1, 1'b1);
    step();
    chk_bit("b2b_valid", o_mac_rlst_valid, 1'b1);
    chk_lane("b2b", 0, 6);
    chk_lane("b2b", 2, 6);
    chk_bit("b2b_idle", o_busy, 1'b0);

    // Saturation vs wrap: 127*127 over 3 taps = 48387
    for (int i = 0; i < NL; i++) load_w(i, 127);
    swap();
    cfg_sat = 1'b1;
    feed(127, 1'b0);
    feed(127, 1'b0);
    feed(127, 1'b1);
    step();
    chk_bit("sat_valid", o_mac_rlst_valid, 1'b1);
    chk_lane("sat", 0, 32767);
    chk_lane("sat", 3, 32767);
    chk_bit("sat_flag", o_sat_flag, 1'b1);
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    chk_bit("clr_satflag", o_sat_flag, 1'b0);
    chk_lane("clr_keeps_out", 0, 32767);
    cfg_sat = 1'b0;
    feed(127, 1'b0);
    feed(127, 1'b0);
    feed(127, 1'b1);
    step();
    chk_lane("wrap", 0, -17149);
    chk_bit("wrap_flag", o_sat_flag, 1'b1);
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    cfg_sat = 1'b1;

    // Weight double-buffer
    for (int i = 0; i < NL; i++) load_w(i, 1);
    swap();
    w_load_valid = 1'b1;
    w_load_lane  = 2'd0;
    w_load_data  = 8'd7;
    feed(2, 1'b0);
    w_load_valid = 1'b0;
    w_swap = 1'b1;
    feed(3, 1'b1);
    w_swap = 1'b0;
    step();
    chk_lane("dbuf_old", 0, 5);
    feed(2, 1'b1);
    step();
    chk_lane("dbuf_new", 0, 14);
    chk_lane("dbuf_new", 1, 2);
    w_load_valid = 1'b1;
    w_load_lane  = 2'd0;
    w_load_data  = 8'd9;
    w_swap       = 1'b1;
    step();
    w_load_valid = 1'b0;
    w_swap       = 1'b0;
    feed(1, 1'b1);
    step();
    chk_lane("loadswap_old", 0, 7);
    swap();
    feed(1, 1'b1);
    step();
    chk_lane("loadswap_new", 0, 9);

    // Overrun: 9 taps without f_last
    for (int k = 0; k < 9; k++) feed(1, 1'b0);
    chk_bit("overrun_taperr", o_tap_err, 1'b1);
    step();
    chk_bit("overrun_valid", o_mac_rlst_valid, 1'b1);
    chk_lane("overrun", 0, 81);
    chk_lane("overrun", 1, 9);
    chk_bit("overrun_idle", o_busy, 1'b0);

    // s_clr one cycle after a sample kills it
    feed(2, 1'b1);
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    chk_bit("clr_kill", o_mac_rlst_valid, 1'b0);
    chk_bit("clr_taperr", o_tap_err, 1'b0);
    chk_bit("clr_sat", o_sat_flag, 1'b0);
    chk_lane("clr_out_kept", 0, 81);
    step();
    chk_bit("clr_kill2", o_mac_rlst_valid, 1'b0);

    // s_clr and sample in the same cycle: sample dropped
    s_clr = 1'b1;
    feed(3, 1'b1);
    s_clr = 1'b0;
    step();
    chk_bit("clr_same", o_mac_rlst_valid, 1'b0);
    chk_bit("clr_same_busy", o_busy, 1'b0);

    // Async reset mid-window
    feed(4, 1'b0);
    chk_bit("mid_busy", o_busy, 1'b1);
    #2;
    s_rst_n = 1'b0;
    #1;
    chk_lane("arst_out", 0, 0);
    chk_bit("arst_valid", o_mac_rlst_valid, 1'b0);
    chk_bit("arst_busy", o_busy, 1'b0);
    #1;
    s_rst_n = 1'b1;
    step();
    feed(5, 1'b1);
    step();
    chk_bit("post_rst_valid", o_mac_rlst_valid, 1'b1);
    chk_lane("post_rst_w0", 0, 0);
    load_w(0, 3);
    swap();
    feed(4, 1'b1);
    step();
    chk_lane("post_rst_clean", 0, 12);
    chk_bit("post_rst_taperr", o_tap_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
